alu_share_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 20 ++
 rtl/alu.sv | 30 +++
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the shared-ALU arbiter.
// State encoding, ALU opcodes and default widths.
package alu_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/alu.sv
// Combinational ALU: and/or/add/sub/signed set-less-than.
// Ports: a, b, alu_control in; result, zero (result == 0) out.
module alu
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [CTRL_W-1:0] alu_control,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (alu_control)
            CTRL_W'(ALU_AND): result = a & b;
            CTRL_W'(ALU_OR):  result = a | b;
            CTRL_W'(ALU_ADD): result = a + b;
            CTRL_W'(ALU_SUB): result = a - b;
            CTRL_W'(ALU_SLT): result = DATA_W'($signed(a) < $signed(b));
            default:          result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters.
// Ports: clk, rst_n; req/rsp valid-ready pairs x2; rsp_result, rsp_zero, busy.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              rr_q, rr_d;
    logic              owner_q, owner_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;

    logic              idle;
    logic              grant0, grant1;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    // Readies are gated by rst_n so nothing handshakes while reset is held.
    assign idle   = rst_n && (state_q == IDLE);
    assign grant0 = idle && req0_valid && (!req1_valid || !rr_q);
    assign grant1 = idle && req1_valid && (!req0_valid || rr_q);

    alu #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
    ) u_alu (
        .a          (a_q),
        .b          (b_q),
        .alu_control(ctrl_q),
        .result     (alu_result),
        .zero       (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        ctrl_d  = ctrl_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    ctrl_d  = req0_ctrl;
                    a_d     = req0_a;
                    b_d     = req0_b;
                    owner_d = 1'b0;
                    state_d = EXEC;
                end else if (grant1) begin
                    ctrl_d  = req1_ctrl;
                    a_d     = req1_a;
                    b_d     = req1_b;
                    owner_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                    rr_d    = ~owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter.
// Directed scenarios plus random ops against a transaction-level model.
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_ctrl = 0, req1_ctrl = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 0, rsp1_ready = 0;
    logic [31:0] rsp_result;
    logic        rsp_zero, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
    );

    function automatic logic [31:0] model(input logic [3:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        req0_valid = 1; req1_valid = 1;
        #1;
        tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctl got %b exp 00000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        tests++;
        if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset_rsp got %h/%b exp 0/0", rsp_result, rsp_zero);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1; req0_ctrl = ALU_ADD; req0_a = 7; req0_b = 5;
        rsp0_ready = 1;
        #1;
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_grant got %b%b exp 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0; req0_a = 32'hdead;
        tests++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b1 || rsp1_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_exec got v%b b%b exp v0 b1", rsp0_valid, busy);
        end
        tick();
        tests++;
        if (rsp0_valid !== 1 || rsp1_valid !== 0 || rsp_result !== 32'd12 || rsp_zero !== 0) begin
            fails++;
            $display("FAIL single_rsp got v%b%b %0d z%b exp v10 12 z0",
                     rsp0_valid, rsp1_valid, rsp_result, rsp_zero);
        end
        tick();
        rsp0_ready = 0;
        tests++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_done got b%b v%b exp 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_zero();
        req1_valid = 1; req1_ctrl = ALU_SUB; req1_a = 32'h1234; req1_b = 32'h1234;
        rsp1_ready = 1;
        #1;
        tests++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            fails++;
            $display("FAIL zero_grant got %b%b exp 01", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 0;
        tick();
        tests++;
        if (rsp1_valid !== 1 || rsp0_valid !== 0 || rsp_result !== 0 || rsp_zero !== 1) begin
            fails++;
            $display("FAIL zero_rsp got v%b %h z%b exp 1 0 z1",
                     rsp1_valid, rsp_result, rsp_zero);
        end
        tick();
        rsp1_ready = 0;
    endtask

    task automatic test_contention();
        int g;
        logic [31:0] exp;
        do_reset();
        req0_valid = 1; req0_ctrl = ALU_OR;  req0_a = 32'hF0; req0_b = 32'h0F;
        req1_valid = 1; req1_ctrl = ALU_AND; req1_a = 32'hFF; req1_b = 32'h0F;
        rsp0_ready = 1; rsp1_ready = 1;
        g = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            else #1;
            case (c % 3)
                0: begin
                    tests++;
                    if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                        fails++;
                        $display("FAIL cont_grant c%0d got %b%b exp g%0d",
                                 c, req0_ready, req1_ready, g);
                    end
                end
                1: begin
                    tests++;
                    if (req0_ready !== 0 || req1_ready !== 0 || busy !== 1) begin
                        fails++;
                        $display("FAIL cont_exec c%0d got r%b%b b%b exp 00 1",
                                 c, req0_ready, req1_ready, busy);
                    end
                end
                default: begin
                    exp = (g == 0) ? 32'hFF : 32'h0F;
                    tests++;
                    if (rsp0_valid !== (g == 0) || rsp1_valid !== (g == 1) ||
                        rsp_result !== exp) begin
                        fails++;
                        $display("FAIL cont_rsp c%0d got v%b%b %h exp g%0d %h",
                                 c, rsp0_valid, rsp1_valid, rsp_result, g, exp);
                    end
                    g = 1 - g;
                end
            endcase
        end
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1; req0_ctrl = ALU_SLT; req0_a = 32'hFFFF_FFFF; req0_b = 1;
        #1;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_grant0 got %b exp 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_ctrl = ALU_ADD; req1_a = 3; req1_b = 4;
        tick();
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (rsp0_valid !== 1 || rsp_result !== 32'd1 || req1_ready !== 0) begin
                fails++;
                $display("FAIL bp_hold k%0d got v%b %h r1%b exp 1 1 0",
                         k, rsp0_valid, rsp_result, req1_ready);
            end
            tick();
        end
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        req0_valid = 1; req0_ctrl = ALU_ADD;
        #1;
        tests++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_next got %b%b exp 01", req0_ready, req1_ready);
        end
        tick();
        clear_inputs();
        rsp1_ready = 1;
        tick();
        tests++;
        if (rsp1_valid !== 1 || rsp_result !== 32'd7) begin
            fails++;
            $display("FAIL bp_rsp1 got v%b %0d exp 1 7", rsp1_valid, rsp_result);
        end
        tick();
        rsp1_ready = 0;
    endtask

    task automatic test_reset_midop();
        req0_valid = 1; req0_ctrl = ALU_AND; req0_a = 1; req0_b = 1;
        rsp0_ready = 1;
        tick();
        req0_valid = 0;
        tick();
        tick();
        rsp0_ready = 0;
        req1_valid = 1; req1_ctrl = ALU_SUB; req1_a = 9; req1_b = 4;
        #1;
        tests++;
        if (req1_ready !== 1'b1) begin
            fails++;
            $display("FAIL rmid_grant1 got %b exp 1", req1_ready);
        end
        tick();
        req1_valid = 0;
        rsp1_ready = 1;
        rst_n = 0;
        req0_valid = 1; req1_valid = 1;
        req0_ctrl = ALU_ADD; req0_a = 2; req0_b = 2;
        #1;
        tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0 ||
            rsp_result !== 0 || rsp_zero !== 0) begin
            fails++;
            $display("FAIL rmid_clear got %b %h %b exp 0",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy},
                     rsp_result, rsp_zero);
        end
        tick();
        tick();
        rst_n = 1;
        #1;
        tests++;
        if (req0_ready !== 1 || req1_ready !== 0 || rsp1_valid !== 0) begin
            fails++;
            $display("FAIL rmid_after got r%b%b v1%b exp 10 0",
                     req0_ready, req1_ready, rsp1_valid);
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 1;
        tick();
        tests++;
        if (rsp0_valid !== 1 || rsp1_valid !== 0 || rsp_result !== 32'd4) begin
            fails++;
            $display("FAIL rmid_rsp got v%b%b %0d exp 10 4",
                     rsp0_valid, rsp1_valid, rsp_result);
        end
        tick();
        clear_inputs();
    endtask

    function automatic logic [3:0] pick_ctrl();
        case ($urandom_range(0, 5))
            0: return ALU_AND;
            1: return ALU_OR;
            2: return ALU_ADD;
            3: return ALU_SUB;
            4: return ALU_SLT;
            default: return 4'($urandom);
        endcase
    endfunction

    task automatic test_random();
        int rr, exp, d, sel;
        logic [31:0] er;
        do_reset();
        rr = 0;
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(1, 3);
            req0_valid = sel[0]; req1_valid = sel[1];
            req0_ctrl = pick_ctrl(); req0_a = $urandom;
            req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            req1_ctrl = pick_ctrl(); req1_a = $urandom;
            req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
            exp = (sel == 3) ? rr : ((sel == 1) ? 0 : 1);
            er = exp ? model(req1_ctrl, req1_a, req1_b)
                     : model(req0_ctrl, req0_a, req0_b);
            #1;
            tests++;
            if (req0_ready !== (exp == 0) || req1_ready !== (exp == 1)) begin
                fails++;
                $display("FAIL rnd_grant n%0d got %b%b exp %0d",
                         n, req0_ready, req1_ready, exp);
            end
            d = $urandom_range(0, 3);
            tick();
            req0_valid = 0; req1_valid = 0;
            req0_a = $urandom; req1_a = $urandom;
            if (exp == 0) begin
                rsp0_ready = (d == 0); rsp1_ready = 1'($urandom);
            end else begin
                rsp1_ready = (d == 0); rsp0_ready = 1'($urandom);
            end
            tests++;
            if (rsp0_valid !== 0 || rsp1_valid !== 0) begin
                fails++;
                $display("FAIL rnd_exec n%0d got %b%b exp 00",
                         n, rsp0_valid, rsp1_valid);
            end
            tick();
            for (int k = 0; k <= d; k++) begin
                if (k == d) begin
                    if (exp == 0) rsp0_ready = 1;
                    else rsp1_ready = 1;
                end
                tests++;
                if (rsp0_valid !== (exp == 0) || rsp1_valid !== (exp == 1) ||
                    rsp_result !== er || rsp_zero !== (er == 0)) begin
                    fails++;
                    $display("FAIL rnd_rsp n%0d k%0d got v%b%b %h z%b exp o%0d %h",
                             n, k, rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
                             exp, er);
                end
                tick();
            end
            rsp0_ready = 0; rsp1_ready = 0;
            rr = 1 - exp;
            tests++;
            if (busy !== 0 || rsp0_valid !== 0 || rsp1_valid !== 0) begin
                fails++;
                $display("FAIL rnd_idle n%0d got b%b v%b%b exp 0",
                         n, busy, rsp0_valid, rsp1_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_contention();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
